debounce_bank: RTL and testbench

Multi-channel, parameterised input conditioner for board push-buttons and switches. Each channel synchronises an asynchronous input, debounces it with a configurable stability window, and outputs a clean level plus one-cycle rise/fall pulses. An optional auto-repeat engine emits periodic press pulses while a key is held. It sits between the board I/O pins and the CPU's input and peripheral logic.

---
 rtl/debounce_bank.sv | 130 +++++++++++++
 tb/tb_debounce_bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// Multi-channel push-button conditioner: synchroniser, debounce window, edge pulses
// and an optional per-channel auto-repeat engine. All outputs are registered.
module debounce_bank #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int DELAY         = 8,
  parameter int CNT_WIDTH     = 4,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_FIRST  = 20,
  parameter int REPEAT_PERIOD = 5,
  parameter int RPT_WIDTH     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] data,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] press,
  output logic                any_press
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = CNT_WIDTH'(DELAY - 1);
  localparam logic [RPT_WIDTH-1:0] FIRST_MAX  = RPT_WIDTH'(REPEAT_FIRST - 1);
  localparam logic [RPT_WIDTH-1:0] PERIOD_MAX = RPT_WIDTH'(REPEAT_PERIOD - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HELD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // Next-cycle debounced transitions and press, shared by the channel regs and any_press.
  logic [CHANNELS-1:0] lvl_up;
  logic [CHANNELS-1:0] lvl_dn;
  logic [CHANNELS-1:0] press_d;

  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [CNT_WIDTH-1:0]   cnt;
      logic                   level_q;
      logic                   rise_q;
      logic                   fall_q;
      logic                   press_q;
      logic                   s;
      logic                   settle;

      assign s         = sync_q[SYNC_STAGES-1];
      assign settle    = (s != level_q) && (cnt == CNT_MAX);
      assign lvl_up[i] = settle & s;
      assign lvl_dn[i] = settle & ~s;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync_q  <= '0;
          cnt     <= '0;
          level_q <= 1'b0;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
          press_q <= 1'b0;
        end else begin
          sync_q  <= {sync_q[SYNC_STAGES-2:0], data[i]};
          rise_q  <= lvl_up[i];
          fall_q  <= lvl_dn[i];
          press_q <= press_d[i];
          // A single agreeing sample restarts the stability window.
          if (s == level_q) begin
            cnt <= '0;
          end else if (cnt == CNT_MAX) begin
            level_q <= s;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
      end

      assign level[i] = level_q;
      assign rise[i]  = rise_q;
      assign fall[i]  = fall_q;
      assign press[i] = press_q;

      if (REPEAT_EN != 0) begin : g_rpt
        logic [1:0]           state;
        logic [RPT_WIDTH-1:0] rcnt;
        logic                 rpt_fire;

        always_comb begin
          rpt_fire = 1'b0;
          case (state)
            ST_HELD:   rpt_fire = (rcnt == FIRST_MAX);
            ST_REPEAT: rpt_fire = (rcnt == PERIOD_MAX);
            default:   rpt_fire = 1'b0;
          endcase
        end

        // A release in the same cycle suppresses a due repeat pulse.
        assign press_d[i] = lvl_up[i] | (rpt_fire & ~lvl_dn[i]);

        always_ff @(posedge clk) begin
          if (rst) begin
            state <= ST_IDLE;
            rcnt  <= '0;
          end else if (lvl_dn[i]) begin
            state <= ST_IDLE;
            rcnt  <= '0;
          end else if (lvl_up[i]) begin
            state <= ST_HELD;
            rcnt  <= '0;
          end else if (state != ST_IDLE) begin
            if (rpt_fire) begin
              state <= ST_REPEAT;
              rcnt  <= '0;
            end else begin
              rcnt <= rcnt + RPT_WIDTH'(1);
            end
          end
        end
      end else begin : g_norpt
        assign press_d[i] = lvl_up[i];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) any_press <= 1'b0;
    else     any_press <= |press_d;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: vector table, directed multi-cycle sequences and a
// randomized run compared against a sample-window reference model.
module tb_debounce_bank;
  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int DEL  = 8;
  localparam int RF   = 20;
  localparam int RP   = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] data;
  logic [CH-1:0] level, rise, fall, press;
  logic          any_press;

  int checks = 0;
  int errors = 0;

  debounce_bank #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .DELAY(DEL), .CNT_WIDTH(4),
    .REPEAT_EN(1), .REPEAT_FIRST(RF), .REPEAT_PERIOD(RP), .RPT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .level(level), .rise(rise),
    .fall(fall), .press(press), .any_press(any_press)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit            raw_q[CH][$];   // data samples taken at each edge since reset
  bit            win_q[CH][$];   // synchronised samples seen by the debouncer
  logic [CH-1:0] m_level, m_rise, m_fall, m_press;
  logic          m_any;
  int            m_age[CH];      // cycles since the last rise

  task automatic model_update(input logic r, input logic [CH-1:0] d);
    m_rise = '0; m_fall = '0; m_press = '0;
    if (r) begin
      for (int c = 0; c < CH; c++) begin
        raw_q[c].delete(); win_q[c].delete(); m_age[c] = 0;
      end
      m_level = '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        bit s;
        bit change;
        s = (raw_q[c].size() >= SYNC) ? raw_q[c][raw_q[c].size() - SYNC] : 1'b0;
        raw_q[c].push_back(d[c]);
        if (raw_q[c].size() > SYNC + 1) void'(raw_q[c].pop_front());
        win_q[c].push_back(s);
        if (win_q[c].size() > DEL) void'(win_q[c].pop_front());
        change = (win_q[c].size() == DEL);
        foreach (win_q[c][k]) if (win_q[c][k] == m_level[c]) change = 0;
        if (change) begin
          m_level[c] = s;
          m_rise[c]  = s;
          m_fall[c]  = !s;
        end
        if (m_rise[c]) m_age[c] = 0;
        else if (m_level[c]) m_age[c]++;
        m_press[c] = m_rise[c] ||
                     (m_level[c] && m_age[c] >= RF && ((m_age[c] - RF) % RP) == 0);
      end
    end
    m_any = |m_press;
  endtask

  // ---------------- driver / checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic [CH-1:0] d);
    rst  = r;
    data = d;
    @(posedge clk);
    model_update(r, d);
    #1;
    check("model_outputs", {15'd0, level, rise, fall, press, any_press},
          {15'd0, m_level, m_rise, m_fall, m_press, m_any});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          r;
    logic [CH-1:0] d;
    logic [CH-1:0] lv, ri, fa, pr;
    logic          an;
  } vec_t;
  vec_t tbl[$];

  logic [7:0] exp_q[$];
  logic [7:0] act_q[$];

  task automatic compare_events(input string name);
    check({name, "_count"}, act_q.size(), exp_q.size());
    foreach (exp_q[k])
      if (k < act_q.size()) check({name, "_edge"}, act_q[k], exp_q[k]);
  endtask

  initial begin
    int fall_e, rise_e, seen;
    logic [CH-1:0] held;
    rst  = 1'b1;
    data = '0;

    // Channels 0 and 3 together: level/rise/press at edge 10, any_press one cycle.
    tbl.push_back('{r: 1'b1, d: 4'b0000, lv: 4'b0, ri: 4'b0, fa: 4'b0, pr: 4'b0, an: 1'b0});
    for (int k = 1; k <= 12; k++)
      tbl.push_back('{r: 1'b0, d: 4'b1001,
                      lv: (k >= 10) ? 4'b1001 : 4'b0000,
                      ri: (k == 10) ? 4'b1001 : 4'b0000,
                      fa: 4'b0000,
                      pr: (k == 10) ? 4'b1001 : 4'b0000,
                      an: (k == 10)});
    foreach (tbl[k]) begin
      cycle(tbl[k].r, tbl[k].d);
      check("tbl_level", level, tbl[k].lv);
      check("tbl_rise",  rise,  tbl[k].ri);
      check("tbl_fall",  fall,  tbl[k].fa);
      check("tbl_press", press, tbl[k].pr);
      check("tbl_any",   any_press, tbl[k].an);
    end

    // Held 40 cycles: press at 10,30,35,40,45; fall at 50 lands on a slot.
    cycle(1'b1, '0);
    exp_q = '{8'd10, 8'd30, 8'd35, 8'd40, 8'd45};
    act_q.delete(); fall_e = 0; seen = 0;
    for (int e = 1; e <= 65; e++) begin
      cycle(1'b0, (e <= 40) ? 4'b0001 : 4'b0000);
      if (press[0]) act_q.push_back(8'(e));
      if (fall[0]) fall_e = e;
      if (level[3:1] != 3'b000) seen = 1;
    end
    compare_events("hold40_press");
    check("hold40_fall_edge", fall_e, 50);
    check("hold40_others_quiet", seen, 0);

    // Release timed so the fall lands on T+30.
    cycle(1'b1, '0);
    exp_q = '{8'd10, 8'd30, 8'd35};
    act_q.delete(); fall_e = 0;
    for (int e = 1; e <= 55; e++) begin
      cycle(1'b0, (e <= 30) ? 4'b0001 : 4'b0000);
      if (press[0]) act_q.push_back(8'(e));
      if (fall[0]) fall_e = e;
      if (e == 40) check("slot_fall_press0", press[0], 1'b0);
    end
    compare_events("slot_press");
    check("slot_fall_edge", fall_e, 40);

    // Ch1: a 7-cycle pulse is rejected, an 8-cycle pulse is accepted.
    cycle(1'b1, '0);
    held = '0;
    for (int e = 1; e <= 30; e++) begin
      cycle(1'b0, (e <= 7) ? 4'b0010 : 4'b0000);
      held = held | level | rise | press;
    end
    check("short_pulse_quiet", held[1], 1'b0);
    rise_e = 0;
    for (int e = 1; e <= 30; e++) begin
      cycle(1'b0, (e <= 8) ? 4'b0010 : 4'b0000);
      if (rise[1]) rise_e = e;
    end
    check("min_pulse_rise_edge", rise_e, 10);

    // Ch2 bounce: 5 high, 1 low, 8 high; window restarts at the 8-cycle run.
    cycle(1'b1, '0);
    rise_e = 0;
    for (int e = 1; e <= 30; e++) begin
      cycle(1'b0, (e <= 5 || (e >= 7 && e <= 14)) ? 4'b0100 : 4'b0000);
      if (rise[2] && rise_e == 0) rise_e = e;
    end
    check("bounce_rise_edge", rise_e, 16);

    // Reset mid-repeat with data still high.
    cycle(1'b1, '0);
    for (int e = 1; e <= 33; e++) cycle(1'b0, 4'b0001);
    cycle(1'b1, 4'b0001);
    check("rst_mid_repeat_clear", {level, rise, fall, press, any_press}, 17'd0);
    rise_e = 0; seen = 0;
    for (int e = 1; e <= 15; e++) begin
      cycle(1'b0, 4'b0001);
      if (rise[0] && rise_e == 0) rise_e = e;
      if (press[0] && seen == 0) seen = e;
    end
    check("rst_rerise_edge", rise_e, 10);
    check("rst_repress_edge", seen, 10);

    // Randomized run: per-channel held levels with glitches and rare resets.
    held = '0;
    for (int n = 0; n < 4000; n++) begin
      logic [CH-1:0] d;
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 39) == 0) held[c] = ~held[c];
      d = held;
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 14) == 0) d[c] = ~d[c];
      cycle($urandom_range(0, 499) == 0, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
